// File: rtl/counter.sv
// Synchronous up-counter with count-enable and a registered one-cycle wrap pulse.
// Reset is synchronous, active-high, and has priority over enable.
module counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] INIT_VALUE = WIDTH'(RESET_VALUE);

    logic [WIDTH:0] sum;

    // The MSB of the widened sum is the carry out, which only ever surfaces as the wrap flag.
    always_comb begin
        sum = {1'b0, count} + (WIDTH + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= INIT_VALUE;
            wrap  <= 1'b0;
        end else if (enable) begin
            count <= sum[WIDTH-1:0];
            wrap  <= sum[WIDTH];
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter.sv
// Bench for counter: a modulo-arithmetic reference model compared every falling edge,
// plus directed sequences with hand-computed expected values.
module tb_counter;

    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 16;
    localparam int unsigned RV  = 0;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [W-1:0] count;
    logic         wrap;

    int vectors     = 0;
    int miscompares = 0;

    counter #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modulo arithmetic, updated on each rising edge.
    int m_count = 0;
    bit m_wrap  = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_count = RV;
            m_wrap  = 1'b0;
            m_valid = 1'b1;
        end else if (enable === 1'b1) begin
            m_wrap  = (m_count == MOD - 1);
            m_count = (m_count + 1) % MOD;
        end else begin
            m_wrap  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", 32'(count), 32'(m_count));
            check("model_wrap", 32'(wrap), 32'(m_wrap));
        end
    end

    // Apply inputs just after a falling edge, then land #1 after the next falling edge.
    task automatic tick(input logic r, input logic e);
        reset  = r;
        enable = e;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        #1;

        // Reset with enable low
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);

        // Basic counting 1..5 then hold
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, 1'b1);
            check("basic_count", 32'(count), 32'(i));
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            check("hold_count", 32'(count), 32'd5);
            check("hold_wrap", 32'(wrap), 32'd0);
        end

        // Full wrap from reset: 1..15 then 0 with a single wrap pulse
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b1);
            check("wrap_count", 32'(count), (i == 16) ? 32'd0 : 32'(i));
            check("wrap_flag", 32'(wrap), (i == 16) ? 32'd1 : 32'd0);
        end
        tick(1'b0, 1'b1);
        check("post_wrap_count", 32'(count), 32'd1);
        check("post_wrap_flag", 32'(wrap), 32'd0);
        tick(1'b0, 1'b0);
        check("post_wrap_hold", 32'(count), 32'd1);

        // Reset priority over enable mid-count
        tick(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
        check("pre_reset_count", 32'(count), 32'd7);
        tick(1'b1, 1'b1);
        check("reset_prio_count", 32'(count), 32'd0);
        tick(1'b1, 1'b1);
        check("reset_held_count", 32'(count), 32'd0);
        tick(1'b0, 1'b1);
        check("resume_count", 32'(count), 32'd1);

        // Reset held with a wrap pending: wrap must not survive reset
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b1);
        check("near_top_count", 32'(count), 32'd15);
        tick(1'b1, 1'b1);
        check("reset_at_top_count", 32'(count), 32'd0);
        check("reset_at_top_wrap", 32'(wrap), 32'd0);

        // Random enable with occasional resets; the model compare checks every cycle
        for (int i = 0; i < 250; i++) begin
            tick(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
        end
        // Long enabled run so the random phase is guaranteed to cross a wrap
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
